// File: rtl/imem_loader.sv
// Boot loader: assembles a little-endian byte stream into 32-bit words, writes them
// to instruction memory, and releases the core from reset once the checksum matches.
module imem_loader #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        core_rst,
  output logic        done,
  output logic        err
);

  localparam int unsigned CW = $clog2(DEPTH_WORDS + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_LOAD,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [1:0]    r_byte_cnt;
  logic [CW-1:0] r_word_cnt;
  logic [CW-1:0] r_n;
  logic [23:0]   r_shift;
  logic [7:0]    r_csum;

  logic          w_accept;
  logic          w_last_byte;
  logic          w_restart;
  logic [31:0]   w_word;
  logic [CW-1:0] w_word_inc;

  // in_ready is only ever high in LEN/LOAD/CHK, so an accepted byte implies one of those states.
  assign w_accept    = in_valid && in_ready;
  assign w_last_byte = w_accept && (r_byte_cnt == 2'd3);
  assign w_word      = {in_data, r_shift};
  assign w_word_inc  = r_word_cnt + CW'(1);
  assign w_restart   = start && ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) w_next = S_LEN;
      end
      S_LEN: begin
        if (w_last_byte) begin
          if (w_word > DEPTH_WORDS)  w_next = S_ERR;
          else if (w_word == '0)     w_next = S_CHK;
          else                       w_next = S_LOAD;
        end
      end
      S_LOAD: begin
        if (w_last_byte && (w_word_inc == r_n)) w_next = S_CHK;
      end
      S_CHK: begin
        if (w_accept) w_next = (in_data == r_csum) ? S_DONE : S_ERR;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_byte_cnt <= '0;
      r_word_cnt <= '0;
      r_n        <= '0;
      r_shift    <= '0;
      r_csum     <= '0;
      in_ready   <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= BASE_ADDR;
      mem_wdata  <= '0;
      core_rst   <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      r_state  <= w_next;
      mem_we   <= 1'b0;
      in_ready <= (w_next == S_LEN) || (w_next == S_LOAD) || (w_next == S_CHK);
      core_rst <= (w_next != S_DONE);
      done     <= (w_next == S_DONE);
      err      <= (w_next == S_ERR);

      if (w_restart) begin
        r_byte_cnt <= '0;
        r_word_cnt <= '0;
        r_shift    <= '0;
        r_csum     <= '0;
      end else if (w_accept) begin
        r_byte_cnt <= r_byte_cnt + 2'd1;
        r_shift    <= {in_data, r_shift[23:8]};
        if ((r_state == S_LEN) && (r_byte_cnt == 2'd3)) begin
          r_n <= w_word[CW-1:0];
        end
        if (r_state == S_LOAD) begin
          r_csum <= r_csum ^ in_data;
          if (r_byte_cnt == 2'd3) begin
            mem_we     <= 1'b1;
            mem_addr   <= BASE_ADDR + (32'(r_word_cnt) << 2);
            mem_wdata  <= w_word;
            r_word_cnt <= w_word_inc;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed images plus randomized images and
// back-pressure, checked against an image-level model of the expected writes and result.
module tb_imem_loader;

  localparam int unsigned DEPTH = 256;
  localparam logic [31:0] BASE  = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_rst;
  logic        done;
  logic        err;

  int unsigned vectors    = 0;
  int unsigned miscompares = 0;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;

  wr_t         wq[$];
  logic [31:0] g_words[$];

  imem_loader #(
    .DEPTH_WORDS(DEPTH),
    .BASE_ADDR  (BASE)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .core_rst (core_rst),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Every cycle with mem_we high is logged as one write.
  always @(negedge clk) begin
    if (mem_we === 1'b1) wq.push_back({mem_addr, mem_wdata});
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit ok;
    int unsigned idle;
    ok   = 1'b0;
    idle = 0;
    if (gaps) begin
      while (($urandom_range(0, 1) == 1) && (idle < 6)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        tick();
        idle++;
      end
    end
    in_valid = 1'b1;
    in_data  = b;
    if (!gaps) chk("no_stall_ready", 32'(in_ready), 32'd1);
    for (int c = 0; c < 16 && !ok; c++) begin
      if (in_ready === 1'b1) ok = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    if (!ok) chk("accept_timeout", 32'd0, 32'd1);
  endtask

  // Streams an image of length field n (words from g_words) and checks writes and outcome.
  task automatic run_image(input logic [31:0] n, input logic [7:0] flip, input bit gaps);
    logic [7:0]  cs;
    logic [31:0] w;
    wq.delete();
    do_start();
    chk("start_ready", 32'(in_ready), 32'd1);
    chk("start_done", 32'(done), 32'd0);
    chk("start_err", 32'(err), 32'd0);
    chk("start_core_rst", 32'(core_rst), 32'd1);
    for (int i = 0; i < 4; i++) send_byte(n[8*i +: 8], gaps);
    if (n > DEPTH) begin
      chk("oversize_err", 32'(err), 32'd1);
      chk("oversize_ready", 32'(in_ready), 32'd0);
      chk("oversize_core_rst", 32'(core_rst), 32'd1);
      chk("oversize_done", 32'(done), 32'd0);
      chk("oversize_writes", 32'(wq.size()), 32'd0);
      return;
    end
    cs = 8'h00;
    for (int unsigned k = 0; k < n; k++) begin
      w = g_words[k];
      for (int i = 0; i < 4; i++) begin
        send_byte(w[8*i +: 8], gaps);
        cs = cs ^ w[8*i +: 8];
        if (i == 3) begin
          chk("we_pulse", 32'(mem_we), 32'd1);
          chk("we_addr", mem_addr, BASE + 32'(k * 4));
          chk("we_data", mem_wdata, w);
        end else begin
          chk("we_idle", 32'(mem_we), 32'd0);
        end
      end
    end
    chk("pre_chk_done", 32'(done), 32'd0);
    send_byte(cs ^ flip, gaps);
    chk("final_done", 32'(done), 32'(flip == 8'h00));
    chk("final_err", 32'(err), 32'(flip != 8'h00));
    chk("final_core_rst", 32'(core_rst), 32'(flip != 8'h00));
    chk("final_ready", 32'(in_ready), 32'd0);
    chk("final_we", 32'(mem_we), 32'd0);
    chk("write_count", 32'(wq.size()), n);
    for (int unsigned k = 0; k < wq.size() && k < n; k++) begin
      chk("log_addr", wq[k].a, BASE + 32'(k * 4));
      chk("log_data", wq[k].d, g_words[k]);
    end
  endtask

  task automatic set_demo_words();
    g_words.delete();
    g_words.push_back(32'h0000_0013);
    g_words.push_back(32'h0010_0093);
  endtask

  initial begin
    logic [31:0] n;
    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) tick();
    chk("rst_ready", 32'(in_ready), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_addr", mem_addr, BASE);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_core_rst", 32'(core_rst), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();

    set_demo_words();
    run_image(32'd2, 8'h00, 1'b0);
    g_words.delete();
    run_image(32'd0, 8'h00, 1'b0);
    set_demo_words();
    run_image(32'd2, 8'h01, 1'b0);
    run_image(32'd257, 8'h00, 1'b0);
    run_image(32'd2, 8'h00, 1'b0);
    run_image(32'h0100_0000, 8'h00, 1'b0);
    run_image(32'd2, 8'h00, 1'b1);

    // Reset after the 6th byte.
    wq.delete();
    do_start();
    send_byte(8'h02, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b0);
    send_byte(8'h13, 1'b0);
    send_byte(8'h00, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrst_ready", 32'(in_ready), 32'd0);
    chk("midrst_we", 32'(mem_we), 32'd0);
    chk("midrst_core_rst", 32'(core_rst), 32'd1);
    chk("midrst_done", 32'(done), 32'd0);
    in_valid = 1'b1;
    repeat (6) tick();
    in_valid = 1'b0;
    chk("midrst_no_writes", 32'(wq.size()), 32'd0);
    chk("midrst_idle_ready", 32'(in_ready), 32'd0);
    run_image(32'd2, 8'h00, 1'b0);

    // Reset coinciding with the byte that completes a word: no write may follow.
    wq.delete();
    do_start();
    send_byte(8'h02, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'h00, 1'b0);
    for (int i = 0; i < 3; i++) send_byte(8'h55, 1'b0);
    in_valid = 1'b1;
    in_data  = 8'hAA;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    chk("rst_pending_we", 32'(mem_we), 32'd0);
    tick();
    chk("rst_pending_writes", 32'(wq.size()), 32'd0);

    g_words.delete();
    for (int k = 0; k < 256; k++) g_words.push_back($urandom);
    run_image(32'd256, 8'h00, 1'b0);

    for (int it = 0; it < 8; it++) begin
      g_words.delete();
      n = 32'($urandom_range(1, 6));
      for (int unsigned k = 0; k < n; k++) g_words.push_back($urandom);
      run_image(n, ($urandom_range(0, 2) == 0) ? 8'($urandom_range(1, 255)) : 8'h00,
                bit'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader and the write side of the core's instruction memory. It accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit words, and writes them sequentially into instruction memory. It holds the RV32E core in reset until a complete image with a matching checksum has been written. It sits between the host/UART byte source and the imem write port, and drives the core's reset.

## Interface
- DEPTH_WORDS, 256, imem capacity in 32-bit words; a word count above this is an error
- BASE_ADDR, 32'h0000_0000, byte address of the first word written
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to begin a load
- in_valid  input  1  byte-stream data valid
- in_data  input  8  byte-stream payload
- in_ready  output  1  loader can accept a byte
- mem_we  output  1  imem write strobe, one cycle per word
- mem_addr  output  32  imem byte address, word aligned
- mem_wdata  output  32  assembled instruction word
- core_rst  output  1  reset to core; high except in DONE
- done  output  1  image loaded and verified
- err  output  1  load failed (oversize or checksum)

## Operation
- A byte is accepted when in_valid && in_ready in the same cycle. No other event consumes a byte.
- Stream format:
  - 4 bytes: word count N, little-endian.
  - N×4 bytes: instruction words, each little-endian.
  - 1 byte: checksum, the XOR of all instruction bytes. Length bytes are excluded.
- States:
  - IDLE: in_ready=0, core_rst=1.
  - LEN: in_ready=1.
  - LOAD: in_ready=1.
  - CHK: in_ready=1.
  - DONE: in_ready=0, core_rst=0, done=1.
  - ERR: in_ready=0, core_rst=1, err=1.
- Transitions:
  - IDLE/DONE/ERR --start--> LEN. This clears the byte counter, word counter, word shift register and checksum accumulator, and drops done/err.
  - start is ignored in LEN/LOAD/CHK.
  - LEN, 4th byte accepted:
    - N > DEPTH_WORDS → ERR.
    - N == 0 → CHK.
    - otherwise → LOAD.
  - LOAD, 4th byte of word k accepted: register the write. If k == N-1 → CHK.
  - CHK, byte accepted: equals accumulator → DONE; otherwise → ERR.
- Word k is written to BASE_ADDR + 4*k. Byte 0 goes to bits [7:0]; byte 3 goes to bits [31:24].
- N comparison is unsigned 32-bit. The word counter is wide enough for DEPTH_WORDS with no wrap.
- No write occurs beyond word N-1.
- Words written before an ERR or reset stay in imem. They are not rolled back.

## Timing
- Reset values:
  - state=IDLE, in_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0.
  - core_rst=1, done=0, err=0.
- All outputs are registered.
- mem_we is high for exactly one cycle: the cycle after the 4th byte of a word is accepted. mem_addr and mem_wdata are valid in that cycle.
- in_ready stays high during the write cycle, so back-to-back bytes every cycle are supported with no stall.
- State changes take effect the cycle after the triggering byte is accepted.
- done/err/core_rst change one cycle after the checksum byte is accepted. On the oversize case they change one cycle after the 4th length byte.
- Gaps in in_valid have no effect on state, counters or accumulator.
- rst high in any cycle has priority over start and byte acceptance. The next cycle is in the reset state, with mem_we=0 even if a write was pending.
- start in the same cycle as an accepted byte (DONE/ERR have in_ready=0): start wins and no byte is consumed.

## Test plan
- Two-word load, no gaps. After start, stream 02 00 00 00, 13 00 00 00, 93 00 10 00, 90.
  - Expect mem_we pulses: addr 0x0 with data 0x00000013, then addr 0x4 with data 0x00100093.
  - Expect done=1, core_rst=0 one cycle after the 0x90 byte.
- N=0: stream 00 00 00 00, 00.
  - Expect no mem_we pulse, then done=1.
- Checksum mismatch: same as the first scenario but with checksum 0x91.
  - Expect both words written, then err=1, core_rst=1, done=0.
- Oversize count, DEPTH_WORDS=256: stream 01 01 00 00 (N=257).
  - Expect err=1 and in_ready=0 one cycle later, with no writes.
  - A following start returns to LEN with err=0.
- Back-pressure: run the first scenario with in_valid randomly low on about 50% of cycles.
  - Expect identical writes and final state, with byte acceptance only when in_valid=1.
- Reset mid-load: assert rst after the 6th byte of the first scenario.
  - Expect IDLE, mem_we=0, core_rst=1 next cycle, and no further writes.
  - A fresh start and full stream then completes with done=1.
